// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: per-neuron MAC over N_IN inputs, bias add, ReLU, saturation.
// Define FC_LEAKY_RELU_EN to use a leaky ReLU (negative slope = 2^-LEAK_SHIFT) instead of plain ReLU.
module fc_layer_engine #(
  parameter int unsigned N_IN       = 256,
  parameter int unsigned N_OUT      = 20,
  parameter int unsigned X_WIDTH    = 2,
  parameter int unsigned W_WIDTH    = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned FRAC_SHIFT = 0,
  parameter int unsigned LEAK_SHIFT = 3,
  localparam int unsigned W_DEPTH   = N_IN * N_OUT,
  localparam int unsigned WA        = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1,
  localparam int unsigned BA        = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int unsigned XA        = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 we_w,
  input  logic [WA-1:0]        w_wraddr,
  input  logic [W_WIDTH-1:0]   w_wrdata,
  input  logic                 we_b,
  input  logic [BA-1:0]        b_wraddr,
  input  logic [W_WIDTH-1:0]   b_wrdata,
  input  logic                 we_x,
  input  logic [XA-1:0]        x_wraddr,
  input  logic [X_WIDTH-1:0]   x_wrdata,
  input  logic [BA-1:0]        out_rdaddr,
  output logic [OUT_WIDTH-1:0] out_rddata,
  output logic                 busy,
  output logic                 done,
  output logic                 sat
);

  localparam int unsigned PW = X_WIDTH + W_WIDTH;
  localparam logic signed [OUT_WIDTH-1:0] O_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] O_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  if (LEAK_SHIFT >= ACC_WIDTH || FRAC_SHIFT >= ACC_WIDTH) begin : g_param_check
    $error("fc_layer_engine: shift parameters must be smaller than ACC_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, MAC, ACT, WB} state_t;

  state_t state, state_nx;
  logic   accept, finish, last_in, last_out;

  logic [XA-1:0] i_cnt;
  logic [BA-1:0] o_cnt;
  logic [WA-1:0] w_rdaddr;
  logic          rd_valid;

  logic signed [X_WIDTH-1:0]   x_mem [N_IN];
  logic signed [W_WIDTH-1:0]   w_mem [W_DEPTH];
  logic signed [W_WIDTH-1:0]   b_mem [N_OUT];
  logic signed [X_WIDTH-1:0]   x_q;
  logic signed [W_WIDTH-1:0]   w_q;
  logic signed [W_WIDTH-1:0]   b_q;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] r_val;
  logic signed [ACC_WIDTH-1:0] act_val;
  logic signed [OUT_WIDTH-1:0] res_val;
  logic                        sat_hit;
  logic signed [OUT_WIDTH-1:0] result [N_OUT];

  assign last_in  = (32'(i_cnt) == N_IN - 1);
  assign last_out = (32'(o_cnt) == N_OUT - 1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nx = MAC;
        accept   = 1'b1;
      end
      MAC:  if (last_in) state_nx = ACT;
      ACT:  state_nx = WB;
      WB: begin
        if (last_out) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end else begin
          state_nx = MAC;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control outputs and sequencing counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      i_cnt    <= '0;
      o_cnt    <= '0;
      w_rdaddr <= '0;
      rd_valid <= 1'b0;
    end else begin
      busy     <= (state_nx != IDLE);
      done     <= finish;
      rd_valid <= (state == MAC);
      if (accept) begin
        i_cnt    <= '0;
        o_cnt    <= '0;
        w_rdaddr <= '0;
      end else if (state == MAC) begin
        i_cnt    <= i_cnt + XA'(1);
        w_rdaddr <= w_rdaddr + WA'(1);
      end else if (state == WB) begin
        i_cnt <= '0;
        if (!last_out) o_cnt <= o_cnt + BA'(1);
      end
    end
  end

  // Parameter stores: writes are blocked while a layer is running
  always_ff @(posedge clk) begin
    if (we_w && !busy && (32'(w_wraddr) < W_DEPTH)) w_mem[w_wraddr] <= w_wrdata;
    if (we_b && !busy && (32'(b_wraddr) < N_OUT))   b_mem[b_wraddr] <= b_wrdata;
    if (we_x && !busy && (32'(x_wraddr) < N_IN))    x_mem[x_wraddr] <= x_wrdata;
    x_q <= x_mem[i_cnt];
    w_q <= w_mem[w_rdaddr];
    b_q <= b_mem[o_cnt];
  end

  assign prod = PW'(x_q) * PW'(w_q);

  // Bias, scaling, activation and saturation of the finished sum
  always_comb begin
    r_val   = (acc + ACC_WIDTH'(b_q)) >>> FRAC_SHIFT;
    act_val = r_val;
    if (r_val < 0) begin
`ifdef FC_LEAKY_RELU_EN
      act_val = r_val >>> LEAK_SHIFT;
`else
      act_val = '0;
`endif
    end
    sat_hit = 1'b0;
    res_val = OUT_WIDTH'(act_val);
    if (act_val > ACC_WIDTH'(O_MAX)) begin
      res_val = O_MAX;
      sat_hit = 1'b1;
    end else if (act_val < ACC_WIDTH'(O_MIN)) begin
      res_val = O_MIN;
      sat_hit = 1'b1;
    end
  end

  // Accumulator, result array and sticky saturation flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      sat <= 1'b0;
      for (int k = 0; k < int'(N_OUT); k++) result[k] <= '0;
    end else begin
      if (state == MAC && i_cnt == '0) acc <= '0;
      else if (rd_valid)               acc <= acc + ACC_WIDTH'(prod);
      if (accept) sat <= 1'b0;
      else if (state == WB && sat_hit) sat <= 1'b1;
      if (state == WB) result[o_cnt] <= res_val;
    end
  end

  assign out_rddata = (32'(out_rdaddr) < N_OUT) ? result[out_rdaddr] : '0;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine (N_IN=4, N_OUT=3): expected layers queued at start, checked at done.
module tb_fc_layer_engine;

  localparam int NI   = 4;
  localparam int NO   = 3;
  localparam int FRAC = 0;
  localparam int LEAK = 3;
  localparam int LAT  = NO * (NI + 2) + 1;

  logic        clk, reset, start;
  logic        we_w, we_b, we_x;
  logic [3:0]  w_wraddr;
  logic [15:0] w_wrdata;
  logic [1:0]  b_wraddr;
  logic [15:0] b_wrdata;
  logic [1:0]  x_wraddr;
  logic [1:0]  x_wrdata;
  logic [1:0]  out_rdaddr;
  logic [15:0] out_rddata;
  logic        busy, done, sat;

  fc_layer_engine #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .we_w(we_w), .w_wraddr(w_wraddr), .w_wrdata(w_wrdata),
    .we_b(we_b), .b_wraddr(b_wraddr), .b_wrdata(b_wrdata),
    .we_x(we_x), .x_wraddr(x_wraddr), .x_wrdata(x_wrdata),
    .out_rdaddr(out_rdaddr), .out_rddata(out_rddata),
    .busy(busy), .done(done), .sat(sat)
  );

  typedef struct packed {
    logic [NO-1:0][15:0] res;
    logic                sat;
    int                  start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   wm [NI*NO];
  int   bm [NO];
  int   xm [NI];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   zero_req = 0;
  int   zero_served = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference layer: plain integer arithmetic over the model stores
  function automatic exp_t model(input int sc);
    exp_t   e;
    longint s;
    e.sat       = 1'b0;
    e.start_cyc = sc;
    for (int o = 0; o < NO; o++) begin
      s = longint'(bm[o]);
      for (int i = 0; i < NI; i++) s += longint'(xm[i]) * longint'(wm[o*NI+i]);
      s = s >>> FRAC;
      if (s < 0) begin
`ifdef FC_LEAKY_RELU_EN
        s = s >>> LEAK;
`else
        s = 0;
`endif
      end
      if (s > 32767) begin
        s = 32767;
        e.sat = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        e.sat = 1'b1;
      end
      e.res[o] = 16'(s);
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, serves post-reset zero checks
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("busy_with_done", longint'(busy), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_latency", longint'(cyc - e.start_cyc), longint'(LAT));
          chk("sat", longint'(sat), longint'(e.sat));
          for (int o = 0; o < NO; o++) begin
            out_rdaddr = 2'(o);
            #1;
            chk($sformatf("result%0d", o), longint'($signed(out_rddata)), longint'($signed(e.res[o])));
          end
          out_rdaddr = 2'(NO);
          #1;
          chk("oor_read", longint'(out_rddata), 0);
        end
      end else if (exp_q.size() > 0 && (cyc - exp_q[0].start_cyc) > 2 * LAT) begin
        chk("done_timeout", 0, 1);
        void'(exp_q.pop_front());
      end
      if (zero_served != zero_req) begin
        zero_served = zero_req;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_sat", longint'(sat), 0);
        for (int o = 0; o < NO; o++) begin
          out_rdaddr = 2'(o);
          #1;
          chk($sformatf("reset_result%0d", o), longint'(out_rddata), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int a, input int d);
    logic signed [15:0] t;
    t = 16'(d);
    we_w = 1'b1; w_wraddr = 4'(a); w_wrdata = t;
    tick();
    we_w = 1'b0;
    if (a < NI*NO) wm[a] = int'(t);
  endtask

  task automatic wr_b(input int a, input int d);
    logic signed [15:0] t;
    t = 16'(d);
    we_b = 1'b1; b_wraddr = 2'(a); b_wrdata = t;
    tick();
    we_b = 1'b0;
    if (a < NO) bm[a] = int'(t);
  endtask

  task automatic wr_x(input int a, input int d);
    logic signed [1:0] t;
    t = 2'(d);
    we_x = 1'b1; x_wraddr = 2'(a); x_wrdata = t;
    tick();
    we_x = 1'b0;
    if (a < NI) xm[a] = int'(t);
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run();
    exp_q.push_back(model(cyc));
    kick();
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * LAT; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    tick();
  endtask

  task automatic load_cfg_a();
    int xa [NI]   = '{1, 1, -1, 0};
    int wa [NI*NO] = '{100, 200, 50, 7, -400, -400, 0, 5, 30, -20, 10, 1};
    int ba [NO]   = '{10, 0, -5};
    for (int i = 0; i < NI; i++) wr_x(i, xa[i]);
    for (int i = 0; i < NI*NO; i++) wr_w(i, wa[i]);
    for (int o = 0; o < NO; o++) wr_b(o, ba[o]);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    we_w = 1'b0; we_b = 1'b0; we_x = 1'b0;
    w_wraddr = '0; w_wrdata = '0; b_wraddr = '0; b_wrdata = '0;
    x_wraddr = '0; x_wrdata = '0; out_rdaddr = '0;
    zero_req = 1;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Worked example: 260 / ReLU of -800 / small negative
    load_cfg_a();
    run();
    drain();

    // Saturating neuron with all inputs at 1
    for (int i = 0; i < NI; i++) wr_x(i, 1);
    for (int i = 0; i < NI; i++) wr_w(2*NI + i, 32767);
    wr_b(2, 32767);
    run();
    drain();

    // Non-saturating run afterwards must clear sat
    load_cfg_a();
    run();
    drain();

    // Start and memory writes while busy must be ignored
    run();
    repeat (5) tick();
    start = 1'b1;
    we_w = 1'b1; w_wraddr = 4'd0; w_wrdata = 16'd999;
    we_b = 1'b1; b_wraddr = 2'd0; b_wrdata = 16'd77;
    we_x = 1'b1; x_wraddr = 2'd0; x_wrdata = 2'b10;
    tick();
    start = 1'b0; we_w = 1'b0; we_b = 1'b0; we_x = 1'b0;
    drain();
    run();
    drain();

    // Out-of-range writes leave the stores untouched
    wr_w(NI*NO, 1234);
    wr_w(15, -1234);
    wr_b(NO, 4321);
    run();
    drain();

    // Reset mid-run: abandoned, no done; a fresh run still produces the worked example
    kick();
    repeat (6) tick();
    reset = 1'b0;
    zero_req = zero_req + 1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    run();
    drain();

    // Randomised layers, mixing small and full-range weights
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NI; i++) wr_x(i, int'($urandom_range(0, 3)));
      for (int i = 0; i < NI*NO; i++)
        wr_w(i, (r % 2 == 0) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 65535)));
      for (int o = 0; o < NO; o++) wr_b(o, int'($urandom_range(0, 8191)) - 4096);
      if ($urandom_range(0, 1) == 1) wr_w(NI*NO + int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
      run();
      drain();
    end

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
